// File: rtl/board_evaluator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_evaluator: scans a snapshotted 3x3 board for a win, one line per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
module board_evaluator #(
  parameter logic [1:0] P1_CODE = 2'b01,
  parameter logic [1:0] P2_CODE = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] pos0,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [8:0] win_mask,
  output logic       draw,
  output logic [3:0] filled,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [2:0]  line_idx;
  logic [17:0] snapshot;
  logic [1:0]  cells [9];
  logic [3:0]  ia, ib, ic;
  logic [8:0]  line_mask;
  logic [1:0]  ca, cb, cc;
  logic        match;
  logic [3:0]  filled_next;
  logic        illegal_next;

  always_comb begin
    for (int i = 0; i < 9; i++) cells[i] = snapshot[2*i +: 2];
  end

  always_comb begin
    ia = 4'd0; ib = 4'd1; ic = 4'd2;
    case (line_idx)
      3'd0: begin ia = 4'd0; ib = 4'd1; ic = 4'd2; end
      3'd1: begin ia = 4'd3; ib = 4'd4; ic = 4'd5; end
      3'd2: begin ia = 4'd6; ib = 4'd7; ic = 4'd8; end
      3'd3: begin ia = 4'd0; ib = 4'd3; ic = 4'd6; end
      3'd4: begin ia = 4'd1; ib = 4'd4; ic = 4'd7; end
      3'd5: begin ia = 4'd2; ib = 4'd5; ic = 4'd8; end
      3'd6: begin ia = 4'd0; ib = 4'd4; ic = 4'd8; end
      default: begin ia = 4'd2; ib = 4'd4; ic = 4'd6; end
    endcase
  end

  always_comb begin
    line_mask = '0;
    line_mask[ia] = 1'b1;
    line_mask[ib] = 1'b1;
    line_mask[ic] = 1'b1;
  end

  assign ca    = cells[ia];
  assign cb    = cells[ib];
  assign cc    = cells[ic];
  // 2'b11 and empty cells can never form a winning line
  assign match = (ca == cb) && (cb == cc) && ((ca == P1_CODE) || (ca == P2_CODE));

  always_comb begin
    filled_next  = '0;
    illegal_next = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if ((cells[i] == P1_CODE) || (cells[i] == P2_CODE)) filled_next = filled_next + 4'd1;
      if (cells[i] == 2'b11) illegal_next = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (match || (line_idx == 3'd7)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_idx <= '0;
      snapshot <= '0;
      winner   <= '0;
      win_mask <= '0;
      draw     <= 1'b0;
      filled   <= '0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snapshot <= {pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1, pos0};
          line_idx <= '0;
        end
        SCAN: begin
          if (match) begin
            winner   <= ca;
            win_mask <= line_mask;
            draw     <= 1'b0;
            filled   <= filled_next;
            illegal  <= illegal_next;
          end else if (line_idx == 3'd7) begin
            winner   <= '0;
            win_mask <= '0;
            draw     <= (filled_next == 4'd9);
            filled   <= filled_next;
            illegal  <= illegal_next;
          end else begin
            line_idx <= line_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_evaluator.sv
`default_nettype none
// Directed, table-driven bench for board_evaluator plus held-start and mid-scan reset sequences.
module tb_board_evaluator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] board;
  logic        busy, done, draw, illegal;
  logic [1:0]  winner;
  logic [8:0]  win_mask;
  logic [3:0]  filled;

  int total = 0;
  int bad   = 0;

  board_evaluator dut (
    .clk(clk), .rst(rst), .start(start),
    .pos0(board[1:0]),   .pos1(board[3:2]),   .pos2(board[5:4]),
    .pos3(board[7:6]),   .pos4(board[9:8]),   .pos5(board[11:10]),
    .pos6(board[13:12]), .pos7(board[15:14]), .pos8(board[17:16]),
    .busy(busy), .done(done), .winner(winner), .win_mask(win_mask),
    .draw(draw), .filled(filled), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] board;
    logic [1:0]  winner;
    logic [8:0]  mask;
    logic        draw;
    logic [3:0]  filled;
    logic        illegal;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [17:0] mk(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after the start edge; lat = edges after the start edge before done is seen.
  task automatic wait_done(input bit release_start, output int lat, output int bc, output bit got);
    got = 1'b0; lat = -1; bc = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (release_start) start = 1'b0;
      if (busy) bc++;
      if (done) begin got = 1'b1; lat = i; end
    end
  endtask

  task automatic check_result(input vec_t v, input bit got, input int lat, input int bc);
    chk({v.name, ".done_seen"}, {31'd0, got}, 32'd1);
    chk({v.name, ".latency"}, lat, v.lat);
    chk({v.name, ".busy_cycles"}, bc, v.lat + 1);
    chk({v.name, ".winner"}, {30'd0, winner}, {30'd0, v.winner});
    chk({v.name, ".win_mask"}, {23'd0, win_mask}, {23'd0, v.mask});
    chk({v.name, ".draw"}, {31'd0, draw}, {31'd0, v.draw});
    chk({v.name, ".filled"}, {28'd0, filled}, {28'd0, v.filled});
    chk({v.name, ".illegal"}, {31'd0, illegal}, {31'd0, v.illegal});
  endtask

  task automatic apply(input vec_t v);
    int lat, bc;
    bit got;
    @(negedge clk);
    board = v.board;
    start = 1'b1;
    @(posedge clk);
    wait_done(1'b1, lat, bc, got);
    check_result(v, got, lat, bc);
    @(negedge clk);
    chk({v.name, ".done_pulse_busy_after"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int   lat, bc;
    bit   got;
    vec_t v;

    vecs[0] = '{"empty", '0, 2'b00, 9'b0, 1'b0, 4'd0, 1'b0, 8};
    vecs[1] = '{"row0_p1", mk(2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0),
                2'b01, 9'b000000111, 1'b0, 4'd3, 1'b0, 1};
    vecs[2] = '{"anti_p2", mk(2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00),
                2'b10, 9'b001010100, 1'b0, 4'd8, 1'b0, 8};
    vecs[3] = '{"draw", mk(2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01),
                2'b00, 9'b0, 1'b1, 4'd9, 1'b0, 8};
    vecs[4] = '{"full_illegal", mk(2'b01, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01),
                2'b00, 9'b0, 1'b0, 4'd8, 1'b1, 8};
    vecs[5] = '{"col1_p2", mk(0, 2'b10, 0, 0, 2'b10, 0, 0, 2'b10, 0),
                2'b10, 9'b010010010, 1'b0, 4'd3, 1'b0, 5};
    vecs[6] = '{"both_win", mk(2'b10, 2'b10, 2'b10, 0, 0, 0, 2'b01, 2'b01, 2'b01),
                2'b10, 9'b000000111, 1'b0, 4'd6, 1'b0, 1};
    vecs[7] = '{"row_of_11", mk(2'b11, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0),
                2'b00, 9'b0, 1'b0, 4'd0, 1'b1, 8};

    rst = 1'b1; start = 1'b0; board = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {19'd0, busy, done, winner, win_mask, draw, filled, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {19'd0, busy, done, winner, win_mask, draw, filled, illegal}, 32'd0);

    for (int i = 0; i < 8; i++) apply(vecs[i]);

    // Start held high; board changes mid-scan must not affect the running scan.
    @(negedge clk);
    board = '0;
    start = 1'b1;
    @(posedge clk);
    #2 board = mk(0, 0, 0, 2'b01, 2'b01, 2'b01, 0, 0, 0);
    wait_done(1'b0, lat, bc, got);
    v = '{"held_first", '0, 2'b00, 9'b0, 1'b0, 4'd0, 1'b0, 8};
    check_result(v, got, lat, bc);
    @(negedge clk);
    chk("held_idle_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    wait_done(1'b1, lat, bc, got);
    v = '{"held_second", '0, 2'b01, 9'b000111000, 1'b0, 4'd3, 1'b0, 2};
    check_result(v, got, lat, bc);

    // Asynchronous reset while line 3 is being evaluated, with a line-6 win pending.
    v = '{"diag_p1", mk(2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 2'b01),
          2'b01, 9'b100010001, 1'b0, 4'd3, 1'b0, 7};
    @(negedge clk);
    board = v.board;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midscan_reset_outputs", {19'd0, busy, done, winner, win_mask, draw, filled, illegal}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_done", {30'd0, done, busy}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("aborted_scan_no_done", {30'd0, done, busy}, 32'd0);
    end
    apply(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_evaluator.md
Name: board_evaluator

Overview:
- Read-side companion of the 3x3 board register bank. It consumes the nine 2-bit position codes (00 empty, 01 player 1, 10 player 2) and, on request, scans the eight winning lines one per clock.
- Reports the winner, the winning-line mask, draw, occupied-cell count and illegal-code detection to the game-control FSM and the display path.
- Uses a start/busy/done handshake; the board is snapshotted at start so concurrent writes cannot corrupt a scan.

Parameters:
- P1_CODE, 2'b01, cell code for player 1.
- P2_CODE, 2'b10, cell code for player 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  scan request; sampled only in IDLE.
- pos0..pos8  in  2 each  board cell codes, cell index = row*3+col.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle onward.
- winner  out  2  00 none, P1_CODE or P2_CODE.
- win_mask  out  9  bit i set when cell i is in the winning line.
- draw  out  1  no winner and all 9 cells hold P1_CODE/P2_CODE.
- filled  out  4  count of cells equal to P1_CODE or P2_CODE (0..9).
- illegal  out  1  at least one snapshot cell equals 2'b11.

Behaviour:
- Reset (async, any state): state=IDLE, line_idx=0, snapshot=0, busy=0, done=0, winner=00, win_mask=0, draw=0, filled=0, illegal=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge k: snapshot <= {pos8..pos0}, line_idx <= 0, state <= SCAN.
  - start=0: remain in IDLE.
- SCAN:
  - Each cycle, combinationally evaluate line L[line_idx] on the snapshot.
  - Match = all three cells equal and equal to P1_CODE or P2_CODE.
  - Line order: 0:{0,1,2} 1:{3,4,5} 2:{6,7,8} 3:{0,3,6} 4:{1,4,7} 5:{2,5,8} 6:{0,4,8} 7:{2,4,6}.
  - On match at the edge: winner <= cell code, win_mask <= line mask, draw <= 0, state <= DONE. Early termination: the first matching line in this order is the only one reported.
  - No match and line_idx<7: line_idx increments.
  - No match and line_idx==7: winner <= 00, win_mask <= 0, draw <= (filled_next==9), state <= DONE.
  - filled and illegal are registered on every SCAN->DONE transition, computed from the snapshot.
- DONE: done=1 for exactly this one cycle, then state <= IDLE.
- Latency (start sampled at edge k):
  - Match on line i: DONE entered at edge k+1+i; done high in the cycle after that edge.
  - No match: DONE entered at edge k+8.
  - Best case 2 cycles from the start edge to the done cycle; worst case 9.
- busy = (state != IDLE). start while busy (SCAN or DONE) is ignored and not queued.
- Result outputs (winner, win_mask, draw, filled, illegal) hold their last values between DONE transitions. They are not cleared at start.
- Code 2'b11: never matches, is not counted in filled, blocks draw, and sets illegal.
- Changes on pos0..pos8 after the start edge have no effect on the current scan.
- Reset mid-scan aborts the scan; no done pulse is produced.
- Both players owning lines (illegal board state): report the first match in line order; no error is flagged.

Test Plan:
- Reset then idle: all outputs 0. start at edge k with all cells 00 -> done high after edge k+8; winner=00, draw=0, filled=0, illegal=0, busy high for 9 cycles.
- pos0=pos1=pos2=01, remaining cells 00, start -> done after edge k+1; winner=01, win_mask=9'b000000111, filled=3, busy high 2 cycles.
- pos2=pos4=pos6=10, other cells mixed non-winning 01/10 with cell 8 empty -> done after edge k+8 (line 7); winner=10, win_mask=9'b001010100, filled=8.
- Full board with no line, codes 01,10,01,01,10,10,10,01,01 for pos0..pos8 -> winner=00, win_mask=0, draw=1, filled=9, done after edge k+8. Repeat with pos4=11 -> draw=0, illegal=1, filled=8.
- Start held high continuously, with the board changed to a row-1 win for 01 (pos3..pos5=01) during the scan of an empty board:
  - The first scan reports winner=00; the new board is ignored mid-scan.
  - Start is ignored during DONE; the next scan is accepted in IDLE.
  - That second scan reports winner=01, win_mask=9'b000111000.
- Assert rst asynchronously (mid-cycle) at line_idx=3 with a pending line-6 win -> all outputs 0 immediately, no done pulse; a fresh start then produces the correct line-6 result, win_mask=9'b100010001.
